// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: unit-select codes,
// ALU_FUN field positions and the sequencer FSM state encoding.
// Optional build macro used elsewhere in this slice: ALU_SEQ_CHECK_EN.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int FUN_SEL_HI = 3;
  localparam int FUN_SEL_LO = 2;
  localparam int FUN_OP_HI  = 1;
  localparam int FUN_OP_LO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  function automatic logic [1:0] fun_unit(input logic [3:0] fun);
    return fun[FUN_SEL_HI:FUN_SEL_LO];
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, response and ALU-side signals for alu_cmd_sequencer.
// slave = sequencer view, master = host plus ALU view.
// Optional macro ALU_SEQ_CHECK_EN adds the rsp_err signal.
interface alu_cmd_sequencer_if #(parameter int WIDTH = 16);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [3:0]         cmd_fun;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_data;
  logic [1:0]         rsp_unit;
`ifdef ALU_SEQ_CHECK_EN
  logic               rsp_err;
`endif

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_fun;

  logic [2*WIDTH-1:0] arith_out;
  logic               arith_flag;
  logic [WIDTH-1:0]   logic_out;
  logic               logic_flag;
  logic [WIDTH-1:0]   cmp_out;
  logic               cmp_flag;
  logic [WIDTH-1:0]   shift_out;
  logic               shift_flag;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    input  arith_out, arith_flag, logic_out, logic_flag,
    input  cmp_out, cmp_flag, shift_out, shift_flag,
`ifdef ALU_SEQ_CHECK_EN
    output rsp_err,
`endif
    output cmd_ready, rsp_valid, rsp_data, rsp_unit,
    output alu_a, alu_b, alu_fun
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    output arith_out, arith_flag, logic_out, logic_flag,
    output cmp_out, cmp_flag, shift_out, shift_flag,
`ifdef ALU_SEQ_CHECK_EN
    input  rsp_err,
`endif
    input  cmd_ready, rsp_valid, rsp_data, rsp_unit,
    input  alu_a, alu_b, alu_fun
  );

endinterface

// File: rtl/alu_result_mux.sv
// Selects the ALU unit result named by fun[3:2] and widens it to 2*WIDTH.
// With ALU_SEQ_CHECK_EN defined, also flags an inconsistent unit flag set.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]         fun,
  input  logic [2*WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0]   logic_out,
  input  logic [WIDTH-1:0]   cmp_out,
  input  logic [WIDTH-1:0]   shift_out,
`ifdef ALU_SEQ_CHECK_EN
  input  logic               arith_flag,
  input  logic               logic_flag,
  input  logic               cmp_flag,
  input  logic               shift_flag,
  output logic               err,
`endif
  output logic [2*WIDTH-1:0] data,
  output logic [1:0]         unit
);

  // Result select; cmp codes are small unsigned values, others are signed.
  always_comb begin
    unit = fun_unit(fun);
    data = '0;
    case (unit)
      UNIT_ARITH: data = arith_out;
      UNIT_LOGIC: data = {{WIDTH{logic_out[WIDTH-1]}}, logic_out};
      UNIT_CMP:   data = {{WIDTH{1'b0}}, cmp_out};
      default:    data = {{WIDTH{shift_out[WIDTH-1]}}, shift_out};
    endcase
  end

`ifdef ALU_SEQ_CHECK_EN
  // Exactly the selected unit's flag must be set; anything else is an error.
  always_comb begin
    err = ({shift_flag, cmp_flag, logic_flag, arith_flag} != (4'b0001 << unit));
  end
`endif

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one ALU operation at a time from a valid/ready command port,
// waits ALU_LAT cycles, and returns the widened unit result.
// Optional macro ALU_SEQ_CHECK_EN adds the registered rsp_err output.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam logic [2:0] LAT_TC = 3'(ALU_LAT);

  seq_state_e         state;
  logic [2:0]         cnt;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [3:0]         alu_fun_q;
  logic               rsp_valid_q;
  logic [2*WIDTH-1:0] rsp_data_q;
  logic [1:0]         rsp_unit_q;
  logic [2*WIDTH-1:0] sel_data;
  logic [1:0]         sel_unit;
`ifdef ALU_SEQ_CHECK_EN
  logic               sel_err;
  logic               rsp_err_q;
`endif

  alu_result_mux #(.WIDTH(WIDTH)) u_mux (
    .fun        (alu_fun_q),
    .arith_out  (bus.arith_out),
    .logic_out  (bus.logic_out),
    .cmp_out    (bus.cmp_out),
    .shift_out  (bus.shift_out),
`ifdef ALU_SEQ_CHECK_EN
    .arith_flag (bus.arith_flag),
    .logic_flag (bus.logic_flag),
    .cmp_flag   (bus.cmp_flag),
    .shift_flag (bus.shift_flag),
    .err        (sel_err),
`endif
    .data       (sel_data),
    .unit       (sel_unit)
  );

  // Ready follows rsp_ready in RESP so a retire and a new accept share one edge.
  assign bus.cmd_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_unit  = rsp_unit_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
`ifdef ALU_SEQ_CHECK_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

  // Sequencer FSM: accept, wait out the ALU latency, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_unit_q  <= '0;
`ifdef ALU_SEQ_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q   <= bus.cmd_a;
            alu_b_q   <= bus.cmd_b;
            alu_fun_q <= bus.cmd_fun;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT_TC) begin
            rsp_data_q  <= sel_data;
            rsp_unit_q  <= sel_unit;
            rsp_valid_q <= 1'b1;
`ifdef ALU_SEQ_CHECK_EN
            rsp_err_q   <= sel_err;
`endif
            state       <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (bus.cmd_valid) begin
              alu_a_q   <= bus.cmd_a;
              alu_b_q   <= bus.cmd_b;
              alu_fun_q <= bus.cmd_fun;
              cnt       <= '0;
              state     <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-stage behavioural ALU.
// Expected responses go into a queue; a negedge monitor pops and compares.
// rsp_err is compared only when ALU_SEQ_CHECK_EN is defined.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  u;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   kill_shift_flag = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  alu_cmd_sequencer_if #(.WIDTH(16)) bus ();

  alu_cmd_sequencer #(.WIDTH(16), .ALU_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_arith(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic signed [31:0] sa, sb;
    sa = 32'(signed'(a));
    sb = 32'(signed'(b));
    case (op)
      2'd0: return sa + sb;
      2'd1: return sa - sb;
      2'd2: return sa * sb;
      default: return (sb != 0) ? sa / sb : 32'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_logic(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [15:0] f_cmp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'd1: return (a == b) ? 16'd1 : 16'd0;
      2'd2: return ($signed(a) > $signed(b)) ? 16'd2 : 16'd0;
      2'd3: return ($signed(a) < $signed(b)) ? 16'd3 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_shift(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a >> 1;
      2'd1: return a << 1;
      2'd2: return b >> 1;
      default: return b << 1;
    endcase
  endfunction

  // One-stage ALU: every unit computes, only the selected unit raises its flag.
  always @(posedge clk) begin
    bus.arith_out  <= f_arith(bus.alu_a, bus.alu_b, bus.alu_fun[1:0]);
    bus.logic_out  <= f_logic(bus.alu_a, bus.alu_b, bus.alu_fun[1:0]);
    bus.cmp_out    <= f_cmp(bus.alu_a, bus.alu_b, bus.alu_fun[1:0]);
    bus.shift_out  <= f_shift(bus.alu_a, bus.alu_b, bus.alu_fun[1:0]);
    bus.arith_flag <= (bus.alu_fun[3:2] == 2'b00);
    bus.logic_flag <= (bus.alu_fun[3:2] == 2'b01);
    bus.cmp_flag   <= (bus.alu_fun[3:2] == 2'b10);
    bus.shift_flag <= (bus.alu_fun[3:2] == 2'b11) && !kill_shift_flag;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare each retired response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(bus.rsp_data), 64'hDEAD);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(x.d));
        check("rsp_unit", 64'(bus.rsp_unit), 64'(x.u));
`ifdef ALU_SEQ_CHECK_EN
        check("rsp_err", 64'(bus.rsp_err), 64'(x.e));
`endif
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                       input bit push, input logic [31:0] d, input logic [1:0] u, input bit e);
    int n;
    exp_t x;
    n = 0;
    if (push) begin
      x.d = d;
      x.u = u;
      x.e = e;
      exp_q.push_back(x);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_fun   = fun;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!bus.rsp_valid && cyc < 50);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    int cyc;
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_fun   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("reset_rsp_unit", 64'(bus.rsp_unit), 64'd0);
    check("reset_alu_a", 64'(bus.alu_a), 64'd0);
    check("reset_alu_fun", 64'(bus.alu_fun), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    // Arith mul -3 * 7, with latency measurement.
    issue(16'hFFFD, 16'h0007, 4'b0010, 1'b1, 32'hFFFF_FFEB, 2'b00, 1'b0);
    wait_rsp(cyc);
    check("arith_latency", 64'(cyc), 64'd2);
    wait_drain();

    // Logic NOR, sign-extended.
    issue(16'h00F0, 16'h000F, 4'b0111, 1'b1, 32'hFFFF_FF00, 2'b01, 1'b0);
    wait_drain();

    // Compare A<B, zero-extended code.
    issue(16'd5, 16'd9, 4'b1011, 1'b1, 32'h0000_0003, 2'b10, 1'b0);
    wait_drain();

    // Shift B>>1 with a positive result.
    issue(16'h0000, 16'hFFFE, 4'b1110, 1'b1, 32'h0000_7FFF, 2'b11, 1'b0);
    wait_drain();

    // Backpressure on a shift A<<1, then retire and accept on one edge.
    bus.rsp_ready = 1'b0;
    issue(16'h8001, 16'h0000, 4'b1101, 1'b1, 32'h0000_0002, 2'b11, 1'b0);
    bus.cmd_a   = 16'h1234;
    bus.cmd_fun = 4'b0000;
    wait_rsp(cyc);
    check("bp_latency", 64'(cyc), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_data", 64'(bus.rsp_data), 64'h0000_0002);
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("bp_alu_a", 64'(bus.alu_a), 64'h8001);
      check("bp_alu_fun", 64'(bus.alu_fun), 64'hD);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    issue(16'h0002, 16'h0003, 4'b0000, 1'b1, 32'h0000_0005, 2'b00, 1'b0);
    check("b2b_rsp_valid_low", 64'(bus.rsp_valid), 64'd0);
    check("b2b_alu_a", 64'(bus.alu_a), 64'h0002);
    wait_drain();

    // Reset while waiting on the ALU: nothing may come out afterwards.
    issue(16'h0001, 16'h0001, 4'b0000, 1'b0, 32'd0, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwait_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rstwait_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rstwait_alu_a", 64'(bus.alu_a), 64'd0);
    check("rstwait_alu_b", 64'(bus.alu_b), 64'd0);
    check("rstwait_alu_fun", 64'(bus.alu_fun), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rstwait_no_rsp", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Reset while holding a response, with cmd_valid high through reset.
    bus.rsp_ready = 1'b0;
    issue(16'h0007, 16'h0007, 4'b0100, 1'b0, 32'd0, 2'b00, 1'b0);
    wait_rsp(cyc);
    check("rstresp_valid_before", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstresp_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    begin
      exp_t x;
      x.d = 32'h0000_0007;
      x.u = 2'b00;
      x.e = 1'b0;
      exp_q.push_back(x);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 16'h0003;
    bus.cmd_b     = 16'h0004;
    bus.cmd_fun   = 4'b0000;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_no_early_accept", 64'(bus.alu_a), 64'd0);
    @(posedge clk);
    #1;
    check("rst_cmd_accept", 64'(bus.alu_a), 64'h0003);
    bus.cmd_valid = 1'b0;
    wait_drain();

    // Flag consistency: shift flag withheld, then correct.
    kill_shift_flag = 1'b1;
    issue(16'h0010, 16'h0000, 4'b1100, 1'b1, 32'h0000_0008, 2'b11, 1'b1);
    wait_drain();
    kill_shift_flag = 1'b0;
    issue(16'h0010, 16'h0000, 4'b1100, 1'b1, 32'h0000_0008, 2'b11, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
